// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: decodes one MIPS instruction, drives the ALU, waits ALU_LAT cycles, returns the result.
// Optional macro ALU_SEQ_ORI_EN adds the ori opcode (zero-extended immediate, gin 001).
module alu_op_sequencer #(
    parameter int DATA_W  = 32,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_gin,
    output logic [4:0]        alu_shamt,
    input  logic [DATA_W-1:0] alu_sum,
    input  logic              alu_zout,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_zero,
    output logic              branch_taken,
    output logic              illegal
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
`ifdef ALU_SEQ_ORI_EN
    localparam logic [5:0] OP_ORI  = 6'b001101;
`endif
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_SRL = 6'b000010;

    localparam logic [3:0] LAT = 4'(ALU_LAT);

    state_t            state;
    logic [3:0]        cnt;
    logic              is_beq;

    logic [5:0]        opc;
    logic [5:0]        funct;
    logic [15:0]       imm;
    logic [DATA_W-1:0] sext;
`ifdef ALU_SEQ_ORI_EN
    logic [DATA_W-1:0] zext;
`endif

    logic              d_ok;
    logic [2:0]        d_gin;
    logic [DATA_W-1:0] d_b;
    logic [4:0]        d_shamt;
    logic              d_beq;

    // Register-number fields are resolved upstream; only opcode/funct/imm matter here.
    logic              unused_fields;
    assign unused_fields = ^instr[25:16];

    assign opc   = instr[31:26];
    assign funct = instr[5:0];
    assign imm   = instr[15:0];
    assign sext  = {{(DATA_W-16){imm[15]}}, imm};
`ifdef ALU_SEQ_ORI_EN
    assign zext  = {{(DATA_W-16){1'b0}}, imm};
`endif

    assign instr_ready = (state == IDLE);

    // Decode opcode/funct into ALU control, operand b, shift amount and legality.
    always_comb begin
        d_ok    = 1'b0;
        d_gin   = 3'b000;
        d_b     = rt_data;
        d_shamt = 5'd0;
        d_beq   = 1'b0;
        unique case (1'b1)
            (opc == OP_R): begin
                d_ok = 1'b1;
                unique case (1'b1)
                    (funct == F_ADD): d_gin = 3'b010;
                    (funct == F_SUB): d_gin = 3'b110;
                    (funct == F_AND): d_gin = 3'b000;
                    (funct == F_OR):  d_gin = 3'b001;
                    (funct == F_SLT): d_gin = 3'b111;
                    (funct == F_SRL): begin
                        d_gin   = 3'b011;
                        d_shamt = instr[10:6];
                    end
                    default: d_ok = 1'b0;
                endcase
            end
            (opc == OP_ADDI),
            (opc == OP_LW),
            (opc == OP_SW): begin
                d_ok  = 1'b1;
                d_gin = 3'b010;
                d_b   = sext;
            end
            (opc == OP_BEQ): begin
                d_ok  = 1'b1;
                d_gin = 3'b110;
                d_beq = 1'b1;
            end
`ifdef ALU_SEQ_ORI_EN
            (opc == OP_ORI): begin
                d_ok  = 1'b1;
                d_gin = 3'b001;
                d_b   = zext;
            end
`endif
            default: d_ok = 1'b0;
        endcase
    end

    // Sequencer FSM: accept, wait for the ALU to settle, hold the result until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            is_beq       <= 1'b0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_gin      <= 3'b000;
            alu_shamt    <= 5'd0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_zero     <= 1'b0;
            branch_taken <= 1'b0;
            illegal      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (instr_valid) begin
                        if (d_ok) begin
                            alu_a     <= rs_data;
                            alu_b     <= d_b;
                            alu_gin   <= d_gin;
                            alu_shamt <= d_shamt;
                            is_beq    <= d_beq;
                            cnt       <= 4'd1;
                            state     <= EXEC;
                        end else begin
                            res_data     <= '0;
                            res_zero     <= 1'b0;
                            branch_taken <= 1'b0;
                            illegal      <= 1'b1;
                            res_valid    <= 1'b1;
                            state        <= DONE;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == LAT) begin
                        res_data     <= alu_sum;
                        res_zero     <= alu_zout;
                        branch_taken <= is_beq & alu_zout;
                        res_valid    <= 1'b1;
                        cnt          <= 4'd0;
                        state        <= DONE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid    <= 1'b0;
                        branch_taken <= 1'b0;
                        illegal      <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
